// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cache memory-port arbiter.
package cache_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Transfer size encodings shared with the caches.
    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/cache_arb_pick.sv
// Grant policy for the cache memory arbiter. Default is D priority with a starvation
// guard; defining CACHE_ARB_RR_EN selects strict round-robin on ties.
module cache_arb_pick
    import cache_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    input  logic             last_gnt,
    output logic             gnt_c
);

`ifdef CACHE_ARB_RR_EN
    localparam int unsigned unused_limit = STARVE_LIMIT;
    logic unused_cnt;
    assign unused_cnt = ^starve_cnt;

    // On a tie the side not served last wins.
    always_comb begin
        gnt_c = GNT_D;
        if (i_req && !d_req) begin
            gnt_c = GNT_I;
        end else if (i_req && d_req) begin
            gnt_c = (last_gnt == GNT_D) ? GNT_I : GNT_D;
        end
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    // D wins ties until I has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        gnt_c = GNT_D;
        if (i_req && !d_req) begin
            gnt_c = GNT_I;
        end else if (i_req && d_req) begin
            if (starve_cnt == CNT_W'(STARVE_LIMIT)) begin
                gnt_c = GNT_I;
            end
        end
    end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one sram-like memory port between the I and D caches, one transaction at a time.
// Optional CACHE_ARB_RR_EN: round-robin ties instead of D priority with starvation guard.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic              i_wr,
    input  logic [SIZE_W-1:0] i_size,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [SIZE_W-1:0] d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,

    output logic              m_req,
    output logic              m_wr,
    output logic [SIZE_W-1:0] m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok
);

    arb_state_e       state, state_nxt;
    logic             gnt, gnt_nxt;
    logic             pick_gnt_c;
    logic [CNT_W-1:0] pick_cnt;
    mem_req_t         i_bus, d_bus, sel_bus;
    logic             gnt_req;

    assign i_bus = {i_wr, i_size, i_addr, i_wdata};
    assign d_bus = {d_wr, d_size, d_addr, d_wdata};

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    cache_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (pick_cnt),
        .last_gnt   (gnt),
        .gnt_c      (pick_gnt_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= GNT_I;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

`ifdef CACHE_ARB_RR_EN
    assign pick_cnt = '0;
`else
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;

    // Counts consecutive D grants that passed over a waiting I request.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (state == IDLE && (i_req || d_req)) begin
            if (pick_gnt_c == GNT_D && i_req) begin
                if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt_nxt = starve_cnt + CNT_W'(1);
                end
            end else begin
                starve_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

    assign pick_cnt = starve_cnt;
`endif

    // Next state and port steering; requests pass through unregistered while in ADDR.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_bus   = (gnt == GNT_D) ? d_bus : i_bus;
        gnt_req   = (gnt == GNT_D) ? d_req : i_req;
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_size    = '0;
        m_addr    = '0;
        m_wdata   = '0;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    gnt_nxt   = pick_gnt_c;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_req   = 1'b1;
                m_wr    = sel_bus.wr;
                m_size  = sel_bus.size;
                m_addr  = sel_bus.addr;
                m_wdata = sel_bus.wdata;
                if (gnt == GNT_D) begin
                    d_addr_ok = m_addr_ok;
                    d_data_ok = m_addr_ok && m_data_ok;
                end else begin
                    i_addr_ok = m_addr_ok;
                    i_data_ok = m_addr_ok && m_data_ok;
                end
                // Address and data completing together skip DATA entirely.
                if (m_addr_ok) begin
                    state_nxt = m_data_ok ? IDLE : DATA;
                end else if (!gnt_req) begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (gnt == GNT_D) begin
                    d_data_ok = m_data_ok;
                end else begin
                    i_data_ok = m_data_ok;
                end
                if (m_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (default and CACHE_ARB_RR_EN builds).
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size, m_size;
    logic [31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int n_iaok = 0, n_idok = 0, n_daok = 0, n_ddok = 0;
    logic order_q[$];

    cache_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_wr      (i_wr),
        .i_size    (i_size),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_rdata   (i_rdata),
        .i_addr_ok (i_addr_ok),
        .i_data_ok (i_data_ok),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_addr_ok (d_addr_ok),
        .d_data_ok (d_data_ok),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok)
    );

    always #5 clk = ~clk;

    // Pulse counters and grant-order log, sampled mid-cycle.
    always @(negedge clk) begin
        if (i_addr_ok) n_iaok++;
        if (i_data_ok) n_idok++;
        if (d_addr_ok) n_daok++;
        if (d_data_ok) n_ddok++;
        if (i_addr_ok || d_addr_ok) order_q.push_back(d_addr_ok);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_req = 0; i_wr = 0; i_size = SIZE_WORD; i_addr = '0; i_wdata = '0;
        d_req = 0; d_wr = 0; d_size = SIZE_WORD; d_addr = '0; d_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        next();
        rst = 1;
        clear_inputs();
        next();
        next();
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_ia, base_id, base_da, base_dd, base_q;
        logic exp_order [10];
`ifdef CACHE_ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        rst = 1;
        clear_inputs();
        next();
        next();
        mid();
        check_eq("rst_state", 32'(dut.state), 32'(IDLE));
        check_eq("rst_gnt", 32'(dut.gnt), 32'd0);
        check_eq("rst_mreq", 32'(m_req), 32'd0);
        check_eq("rst_oks", 32'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 32'd0);
        next();
        rst = 0;

        // Single D read with waits on both handshakes.
        base_ia = n_iaok; base_id = n_idok; base_da = n_daok; base_dd = n_ddok;
        d_req = 1; d_addr = 32'h0000_1004;
        mid();
        check_eq("t1_idle_mreq", 32'(m_req), 32'd0);
        check_eq("t1_idle_maddr", m_addr, 32'd0);
        next(); mid();
        check_eq("t1_a1_mreq", 32'(m_req), 32'd1);
        check_eq("t1_a1_maddr", m_addr, 32'h0000_1004);
        check_eq("t1_a1_daok", 32'(d_addr_ok), 32'd0);
        next();
        next(); m_addr_ok = 1; mid();
        check_eq("t1_a3_daok", 32'(d_addr_ok), 32'd1);
        check_eq("t1_a3_iaok", 32'(i_addr_ok), 32'd0);
        next(); m_addr_ok = 0; d_req = 0; mid();
        check_eq("t1_d1_mreq", 32'(m_req), 32'd0);
        check_eq("t1_d1_state", 32'(dut.state), 32'(DATA));
        next();
        next(); m_data_ok = 1; m_rdata = 32'hDEAD_BEEF; mid();
        check_eq("t1_d3_ddok", 32'(d_data_ok), 32'd1);
        check_eq("t1_d3_rdata", d_rdata, 32'hDEAD_BEEF);
        next(); m_data_ok = 0; mid();
        check_eq("t1_end_state", 32'(dut.state), 32'(IDLE));
        check_eq("t1_cnt_daok", 32'(n_daok - base_da), 32'd1);
        check_eq("t1_cnt_ddok", 32'(n_ddok - base_dd), 32'd1);
        check_eq("t1_cnt_iaok", 32'(n_iaok - base_ia), 32'd0);
        check_eq("t1_cnt_idok", 32'(n_idok - base_id), 32'd0);

        // Both sides requesting, zero-wait downstream: grant order.
        do_reset();
        base_q = order_q.size();
        i_req = 1; d_req = 1; m_addr_ok = 1; m_data_ok = 1;
        for (int c = 0; c < 40 && order_q.size() < base_q + 10; c++) next();
        check_eq("t2_grants", 32'(order_q.size() >= base_q + 10), 32'd1);
        if (order_q.size() >= base_q + 10) begin
            for (int k = 0; k < 10; k++)
                check_eq($sformatf("t2_order%0d", k), 32'(order_q[base_q + k]), 32'(exp_order[k]));
        end

        // D write-back: write attributes pass through during ADDR.
        do_reset();
        d_req = 1; d_wr = 1; d_wdata = 32'h1234_5678; d_addr = 32'h8000_0040;
        next(); mid();
        check_eq("t3_mwr", 32'(m_wr), 32'd1);
        check_eq("t3_maddr", m_addr, 32'h8000_0040);
        check_eq("t3_mwdata", m_wdata, 32'h1234_5678);
        check_eq("t3_msize", 32'(m_size), 32'(SIZE_WORD));
        next(); m_addr_ok = 1; mid();
        check_eq("t3_daok", 32'(d_addr_ok), 32'd1);
        next(); m_addr_ok = 0; d_req = 0; d_wr = 0; mid();
        check_eq("t3_data_mreq", 32'(m_req), 32'd0);
        next(); m_data_ok = 1; mid();
        check_eq("t3_ddok", 32'(d_data_ok), 32'd1);
        check_eq("t3_idok", 32'(i_data_ok), 32'd0);
        next(); m_data_ok = 0;

        // Address and data done in one cycle, then regrant and abort.
        do_reset();
        i_req = 1; i_addr = 32'h0000_0200;
        next(); m_addr_ok = 1; m_data_ok = 1; mid();
        check_eq("t4_iaok", 32'(i_addr_ok), 32'd1);
        check_eq("t4_idok", 32'(i_data_ok), 32'd1);
        check_eq("t4_d_oks", 32'({d_addr_ok, d_data_ok}), 32'd0);
        next(); m_addr_ok = 0; m_data_ok = 0; mid();
        check_eq("t4_back_idle", 32'(dut.state), 32'(IDLE));
        check_eq("t4_idle_mreq", 32'(m_req), 32'd0);
        next(); mid();
        check_eq("t4_regrant_mreq", 32'(m_req), 32'd1);
        check_eq("t4_regrant_addr", m_addr, 32'h0000_0200);
        next(); i_req = 0;

        // Reset during DATA, then a stale m_data_ok is ignored.
        do_reset();
        base_id = n_idok; base_dd = n_ddok;
        d_req = 1;
        next(); m_addr_ok = 1;
        next(); m_addr_ok = 0; d_req = 0; rst = 1; mid();
        check_eq("t5_in_data", 32'(dut.state), 32'(DATA));
        next(); rst = 0; mid();
        check_eq("t5_rst_state", 32'(dut.state), 32'(IDLE));
        check_eq("t5_rst_mreq", 32'(m_req), 32'd0);
        next(); m_data_ok = 1; mid();
        check_eq("t5_stale_ddok", 32'(d_data_ok), 32'd0);
        next(); m_data_ok = 0; mid();
        check_eq("t5_stale_state", 32'(dut.state), 32'(IDLE));
        check_eq("t5_stale_mreq", 32'(m_req), 32'd0);
        check_eq("t5_dok_count", 32'((n_ddok - base_dd) + (n_idok - base_id)), 32'd0);

        // I aborts in ADDR; pending D is then served.
        do_reset();
        i_req = 1; i_addr = 32'h0000_0300;
        next(); i_req = 0; d_req = 1; d_addr = 32'h0000_0400; mid();
        check_eq("t6_abort_iaok", 32'(i_addr_ok), 32'd0);
        next(); mid();
        check_eq("t6_abort_state", 32'(dut.state), 32'(IDLE));
        check_eq("t6_abort_mreq", 32'(m_req), 32'd0);
        next(); m_addr_ok = 1; m_data_ok = 1; mid();
        check_eq("t6_d_maddr", m_addr, 32'h0000_0400);
        check_eq("t6_d_gnt", 32'(dut.gnt), 32'd1);
        check_eq("t6_d_daok", 32'(d_addr_ok), 32'd1);
        check_eq("t6_d_ddok", 32'(d_data_ok), 32'd1);
        next(); clear_inputs();
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single sram-like memory port toward the AXI bridge between the instruction cache (I side) and the data cache (D side).
- Sits between both cache miss/write-back ports and the sram-to-AXI converter.
- Allows one outstanding transaction at a time: grant, address handshake, data handshake, release.
- D side has priority; a starvation guard protects the I side.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while I is waiting before I is forced. Legal range 1..15.
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-side request
- i_wr  in  1  I-side write (normally 0)
- i_size  in  2  I-side size
- i_addr  in  32  I-side address
- i_wdata  in  32  I-side write data
- i_rdata  out  32  read data to I side
- i_addr_ok  out  1  I-side address accepted
- i_data_ok  out  1  I-side data done
- d_req, d_wr, d_size, d_addr, d_wdata, d_rdata, d_addr_ok, d_data_ok: same as the I-side signals, for the D side
- m_req  out  1  downstream request
- m_wr  out  1  downstream write
- m_size  out  2  downstream size
- m_addr  out  32  downstream address
- m_wdata  out  32  downstream write data
- m_rdata  in  32  downstream read data
- m_addr_ok  in  1  downstream address accepted
- m_data_ok  in  1  downstream data done

Behaviour:
- State machine: IDLE, ADDR, DATA. Registers: state, gnt (0=I, 1=D), starve_cnt.
- Reset: state=IDLE, gnt=0, starve_cnt=0. All *_addr_ok, *_data_ok and m_req are 0.
- Data outputs are don't-care while their valid is low; drive 0 in IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise register gnt and move to ADDR. This costs 1 cycle of arbitration latency.
  - Selection: D only -> D. I only -> I. Both -> D, unless starve_cnt == STARVE_LIMIT, in which case I.
- ADDR:
  - m_req=1. m_wr, m_size, m_addr and m_wdata pass through combinationally from the granted side.
  - Granted side's addr_ok = m_addr_ok. Other side's addr_ok = 0.
  - On m_addr_ok, go to DATA.
  - If the granted req drops without m_addr_ok (protocol abort), return to IDLE and issue nothing.
- DATA:
  - m_req=0. Granted side's data_ok = m_data_ok. Other side's data_ok = 0.
  - On m_data_ok, go to IDLE.
  - The same requester may be regranted by IDLE arbitration 1 cycle later.
- m_addr_ok and m_data_ok asserted in the same ADDR cycle: forward both to the granted side and go directly to IDLE.
- i_rdata and d_rdata both = m_rdata at all times; only data_ok qualifies them.
- Starvation counter, updated on each grant decision in IDLE:
  - D granted while i_req=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - I granted: starve_cnt=0.
  - D granted while i_req=0: starve_cnt=0.
- m_data_ok in IDLE (stale, e.g. after reset mid-transaction) is ignored. No data_ok is forwarded and no state changes.
- The arbiter never issues a second m_req before the prior m_data_ok.
- Reset asserted in ADDR or DATA: next cycle in IDLE, all outputs at reset values.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined: strict round-robin. When both sides request, grant the side that was not granted last (last_gnt register, reset 0 = I last, so D wins the first tie). starve_cnt logic is removed. STARVE_LIMIT is ignored.
- Undefined: D priority with the starvation guard, as above.

Decomposition:
- Package cache_arb_pkg: state encodings IDLE=2'b00, ADDR=2'b01, DATA=2'b10; GNT_I=1'b0, GNT_D=1'b1; size encodings shared with the caches (byte 2'b00, half 2'b01, word 2'b10).
- Sub-module cache_arb_pick: combinational grant selection from i_req, d_req, starve_cnt and last_gnt. Isolates the policy so the CACHE_ARB_RR_EN variant touches one file.
- Port mux and FSM stay in the top module.

Test Plan:
- Single D read, addr 0x0000_1004; m_addr_ok 2 cycles after m_req; m_data_ok 3 cycles later with m_rdata=0xDEADBEEF -> d_addr_ok and d_data_ok each pulse once, d_rdata=0xDEADBEEF, i_addr_ok and i_data_ok stay 0.
- i_req and d_req both held high, STARVE_LIMIT=4, zero-wait downstream -> grant order D,D,D,D,I,D,D,D,D,I. With CACHE_ARB_RR_EN: D,I,D,I.
- D write-back (d_wr=1, d_wdata=0x12345678, d_addr=0x8000_0040) -> m_wr=1, m_addr and m_wdata match during ADDR; m_req deasserts in DATA.
- Downstream asserts m_addr_ok and m_data_ok in the same cycle -> granted side gets both pulses in that cycle; FSM returns to IDLE; next grant 1 cycle later.
- rst pulsed while in DATA, then a stale m_data_ok 2 cycles later -> no *_data_ok pulses, state stays IDLE, m_req=0.
- i_req drops in ADDR before m_addr_ok -> FSM returns to IDLE; a pending d_req is then granted normally.
